// File: rtl/gb_cart_pkg.sv
// Shared constants, FSM state type and bank-mask lookups for the cartridge header snooper.
package gb_cart_pkg;

    localparam int unsigned HDR_BASE   = 32'h134;
    localparam int unsigned HDR_LEN    = 26;
    localparam int unsigned OFS_CGB    = 32'h143;
    localparam int unsigned OFS_TYPE   = 32'h147;
    localparam int unsigned OFS_ROM    = 32'h148;
    localparam int unsigned OFS_RAM    = 32'h149;
    localparam int unsigned OFS_DEST   = 32'h14A;
    localparam int unsigned OFS_LIC    = 32'h14B;
    localparam int unsigned OFS_VER    = 32'h14C;
    localparam int unsigned OFS_CHK    = 32'h14D;
    localparam int unsigned LOGO_BASE  = 32'h104;
    localparam int unsigned LOGO2_BASE = 32'h40104;
    localparam int unsigned LOGO_LEN   = 16;

    localparam int unsigned IDX_CGB  = OFS_CGB  - HDR_BASE;
    localparam int unsigned IDX_TYPE = OFS_TYPE - HDR_BASE;
    localparam int unsigned IDX_ROM  = OFS_ROM  - HDR_BASE;
    localparam int unsigned IDX_RAM  = OFS_RAM  - HDR_BASE;
    localparam int unsigned IDX_CHK  = OFS_CHK  - HDR_BASE;

    localparam logic [7:0] ROM_ONLY    = 8'h00;
    localparam logic [7:0] ROM_RAM     = 8'h08;
    localparam logic [7:0] ROM_RAM_BAT = 8'h09;
    localparam logic [7:0] MBC1_FIRST  = 8'h01;
    localparam logic [7:0] MBC1_LAST   = 8'h03;
    localparam logic [7:0] MBC2_FIRST  = 8'h05;
    localparam logic [7:0] MBC2_LAST   = 8'h06;
    localparam logic [7:0] MBC3_FIRST  = 8'h0F;
    localparam logic [7:0] MBC3_LAST   = 8'h13;
    localparam logic [7:0] MBC5_FIRST  = 8'h19;
    localparam logic [7:0] MBC5_LAST   = 8'h1E;
    localparam logic [7:0] MBC1M_ROM_CODE = 8'h05;

    typedef enum logic [1:0] {IDLE, LOAD, DECODE, DONE} state_t;

    function automatic logic [3:0] ram_mask_lut(input logic [7:0] code);
        case (code)
            8'h00, 8'h01, 8'h02: return 4'h0;
            8'h03:               return 4'h3;
            8'h04:               return 4'hF;
            8'h05:               return 4'h7;
            default:             return 4'hF;
        endcase
    endfunction

    function automatic logic [8:0] rom_mask_lut(input logic [7:0] code);
        logic [9:0] m;
        if (code > 8'd8) return '1;
        m = (10'd2 << code[3:0]) - 10'd1;
        return m[8:0];
    endfunction

endpackage

// File: rtl/gb_cart_hdr_decode.sv
// Combinational decode of captured header bytes into mapper flags, bank masks and checksum status.
module gb_cart_hdr_decode
    import gb_cart_pkg::*;
(
    input  logic [HDR_LEN-1:0][7:0] hdr_bytes,
    input  logic [HDR_LEN-1:0]      hdr_seen,
    output logic                    mbc1,
    output logic                    mbc2,
    output logic                    mbc3,
    output logic                    mbc5,
    output logic                    has_ram,
    output logic [3:0]              ram_mask,
    output logic [8:0]              rom_mask,
    output logic                    hdr_valid,
    output logic                    hdr_chk_ok,
    output logic                    unsupported
);

    logic [7:0] mtype, rom_code, ram_code, sum, chk;
    logic       valid, is1, is2, is3, is5, is_plain;

    always_comb begin
        mtype    = hdr_bytes[IDX_TYPE];
        rom_code = hdr_bytes[IDX_ROM];
        ram_code = hdr_bytes[IDX_RAM];
        valid    = &hdr_seen;

        // c = sum over n bytes of (-b - 1) == -(sum of bytes) - n
        sum = '0;
        for (int unsigned i = 0; i < IDX_CHK; i++) sum = sum + hdr_bytes[5'(i)];
        chk = 8'h00 - sum - 8'(IDX_CHK);

        is1      = mtype inside {[MBC1_FIRST:MBC1_LAST]};
        is2      = mtype inside {[MBC2_FIRST:MBC2_LAST]};
        is3      = mtype inside {[MBC3_FIRST:MBC3_LAST]};
        is5      = mtype inside {[MBC5_FIRST:MBC5_LAST]};
        is_plain = mtype inside {ROM_ONLY, ROM_RAM, ROM_RAM_BAT};

        mbc1        = valid & is1;
        mbc2        = valid & is2;
        mbc3        = valid & is3;
        mbc5        = valid & is5;
        unsupported = ~(is1 | is2 | is3 | is5 | is_plain);
        has_ram     = valid & (is2 | (ram_code != 8'h00));
        ram_mask    = valid ? ram_mask_lut(ram_code) : '0;
        rom_mask    = valid ? rom_mask_lut(rom_code) : '0;
        hdr_valid   = valid;
        hdr_chk_ok  = valid & (chk == hdr_bytes[IDX_CHK]);
    end

endmodule

// File: rtl/gb_cart_header.sv
// Snoops the ROM download stream, captures the cartridge header and registers its decode at end of load.
// Define GB_MBC1M_DETECT_EN to also capture both logo copies and detect MBC1 multicarts.
module gb_cart_header
    import gb_cart_pkg::*;
#(
    parameter int unsigned ADDR_W = 25
)
(
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [15:0]       dl_data,
    output logic [7:0]        cart_mbc_type,
    output logic [7:0]        cart_rom_size,
    output logic [7:0]        cart_ram_size,
    output logic [7:0]        cart_cgb_flag,
    output logic              mbc1,
    output logic              mbc1m,
    output logic              mbc2,
    output logic              mbc3,
    output logic              mbc5,
    output logic              has_ram,
    output logic [3:0]        ram_mask,
    output logic [8:0]        rom_mask,
    output logic              hdr_valid,
    output logic              hdr_chk_ok,
    output logic              unsupported
);

    state_t state, state_nx;
    logic   dl_active_q, start, cap_en;

    logic [HDR_LEN-1:0][7:0]  hdr_bytes;
    logic [HDR_LEN-1:0]       hdr_seen;
    logic [1:0][ADDR_W-1:0]   byte_addr, hdr_off;
    logic [1:0][7:0]          byte_data;
    logic [1:0]               hdr_hit;

    logic       dec_mbc1, dec_mbc2, dec_mbc3, dec_mbc5, dec_has_ram;
    logic       dec_valid, dec_chk_ok, dec_unsupported;
    logic [3:0] dec_ram_mask;
    logic [8:0] dec_rom_mask;

    always_comb begin
        byte_addr[0] = dl_addr & ~ADDR_W'(1);
        byte_addr[1] = dl_addr |  ADDR_W'(1);
        byte_data[0] = dl_data[7:0];
        byte_data[1] = dl_data[15:8];
        for (int unsigned b = 0; b < 2; b++) begin
            hdr_off[b] = byte_addr[b] - ADDR_W'(HDR_BASE);
            hdr_hit[b] = hdr_off[b] < ADDR_W'(HDR_LEN);
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            IDLE, DONE: if (dl_active && !dl_active_q) begin
                start    = 1'b1;
                state_nx = LOAD;
            end
            LOAD:    if (!dl_active) state_nx = DECODE;
            DECODE:  state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        cap_en = (state == LOAD) && dl_active && dl_wr;
    end

    // Edge history resets high so a download still asserted across reset is never re-armed.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state       <= IDLE;
            dl_active_q <= 1'b1;
        end else begin
            state       <= state_nx;
            dl_active_q <= dl_active;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n || start) begin
            hdr_bytes <= '0;
            hdr_seen  <= '0;
        end else if (cap_en) begin
            for (int unsigned b = 0; b < 2; b++) begin
                if (hdr_hit[b]) begin
                    hdr_bytes[hdr_off[b][4:0]] <= byte_data[b];
                    hdr_seen[hdr_off[b][4:0]]  <= 1'b1;
                end
            end
        end
    end

    gb_cart_hdr_decode u_decode (
        .hdr_bytes   (hdr_bytes),
        .hdr_seen    (hdr_seen),
        .mbc1        (dec_mbc1),
        .mbc2        (dec_mbc2),
        .mbc3        (dec_mbc3),
        .mbc5        (dec_mbc5),
        .has_ram     (dec_has_ram),
        .ram_mask    (dec_ram_mask),
        .rom_mask    (dec_rom_mask),
        .hdr_valid   (dec_valid),
        .hdr_chk_ok  (dec_chk_ok),
        .unsupported (dec_unsupported)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cart_mbc_type <= '0;
            cart_rom_size <= '0;
            cart_ram_size <= '0;
            cart_cgb_flag <= '0;
            mbc1          <= 1'b0;
            mbc2          <= 1'b0;
            mbc3          <= 1'b0;
            mbc5          <= 1'b0;
            has_ram       <= 1'b0;
            ram_mask      <= '0;
            rom_mask      <= '0;
            hdr_valid     <= 1'b0;
            hdr_chk_ok    <= 1'b0;
            unsupported   <= 1'b0;
        end else if (state == DECODE) begin
            cart_mbc_type <= hdr_bytes[IDX_TYPE];
            cart_rom_size <= hdr_bytes[IDX_ROM];
            cart_ram_size <= hdr_bytes[IDX_RAM];
            cart_cgb_flag <= hdr_bytes[IDX_CGB];
            mbc1          <= dec_mbc1;
            mbc2          <= dec_mbc2;
            mbc3          <= dec_mbc3;
            mbc5          <= dec_mbc5;
            has_ram       <= dec_has_ram;
            ram_mask      <= dec_ram_mask;
            rom_mask      <= dec_rom_mask;
            hdr_valid     <= dec_valid;
            hdr_chk_ok    <= dec_chk_ok;
            unsupported   <= dec_unsupported;
        end
    end

`ifdef GB_MBC1M_DETECT_EN
    logic [LOGO_LEN-1:0][7:0] logo_a, logo_b;
    logic [LOGO_LEN-1:0]      logo_seen_a, logo_seen_b;
    logic [1:0][ADDR_W-1:0]   off_a, off_b;
    logic [1:0]               hit_a, hit_b;
    logic                     logo_ok;

    always_comb begin
        for (int unsigned b = 0; b < 2; b++) begin
            off_a[b] = byte_addr[b] - ADDR_W'(LOGO_BASE);
            off_b[b] = byte_addr[b] - ADDR_W'(LOGO2_BASE);
            hit_a[b] = off_a[b] < ADDR_W'(LOGO_LEN);
            hit_b[b] = off_b[b] < ADDR_W'(LOGO_LEN);
        end
        logo_ok = (&logo_seen_a) & (&logo_seen_b) & (logo_a == logo_b);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n || start) begin
            logo_a      <= '0;
            logo_b      <= '0;
            logo_seen_a <= '0;
            logo_seen_b <= '0;
        end else if (cap_en) begin
            for (int unsigned b = 0; b < 2; b++) begin
                if (hit_a[b]) begin
                    logo_a[off_a[b][3:0]]      <= byte_data[b];
                    logo_seen_a[off_a[b][3:0]] <= 1'b1;
                end
                if (hit_b[b]) begin
                    logo_b[off_b[b][3:0]]      <= byte_data[b];
                    logo_seen_b[off_b[b][3:0]] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n)
            mbc1m <= 1'b0;
        else if (state == DECODE)
            mbc1m <= dec_mbc1 & (hdr_bytes[IDX_ROM] == MBC1M_ROM_CODE) & logo_ok;
    end
`else
    assign mbc1m = 1'b0;
`endif

endmodule

// File: tb/tb_gb_cart_header.sv
// Self-checking bench for gb_cart_header: table vectors, hand sequences and randomized downloads vs. a header model.
module tb_gb_cart_header;

    logic        clk_sys = 1'b0;
    logic        reset_n, dl_active, dl_wr;
    logic [24:0] dl_addr;
    logic [15:0] dl_data;
    logic [7:0]  cart_mbc_type, cart_rom_size, cart_ram_size, cart_cgb_flag;
    logic        mbc1, mbc1m, mbc2, mbc3, mbc5, has_ram, hdr_valid, hdr_chk_ok, unsupported;
    logic [3:0]  ram_mask;
    logic [8:0]  rom_mask;

    always #5 clk_sys = ~clk_sys;

    gb_cart_header #(.ADDR_W(25)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data),
        .cart_mbc_type(cart_mbc_type), .cart_rom_size(cart_rom_size),
        .cart_ram_size(cart_ram_size), .cart_cgb_flag(cart_cgb_flag),
        .mbc1(mbc1), .mbc1m(mbc1m), .mbc2(mbc2), .mbc3(mbc3), .mbc5(mbc5),
        .has_ram(has_ram), .ram_mask(ram_mask), .rom_mask(rom_mask),
        .hdr_valid(hdr_valid), .hdr_chk_ok(hdr_chk_ok), .unsupported(unsupported)
    );

    typedef struct {
        logic [7:0] typ, rom, ram, cgb;
        logic       m1, m1m, m2, m3, m5, has_ram;
        logic [3:0] ram_mask;
        logic [8:0] rom_mask;
        logic       valid, chk_ok, unsup;
    } exp_t;

    typedef struct {
        logic [7:0] typ, rom, ram;
        bit         corrupt;
        int         map;
        logic [8:0] rom_mask;
        logic [3:0] ram_mask;
        bit         has_ram, chk_ok, unsup;
    } vec_t;

`ifdef GB_MBC1M_DETECT_EN
    localparam bit EXP_M1M_DUP = 1'b1;
`else
    localparam bit EXP_M1M_DUP = 1'b0;
`endif

    logic [7:0] img [0:511];
    logic [7:0] logo2 [0:15];
    bit         sent [0:511];
    bit         logo2_sent [0:15];
    logic [7:0] typ_pool [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06,
                                  8'h08, 8'h09, 8'h0F, 8'h13, 8'h19, 8'h1E};
    int    n_vec = 0, n_bad = 0;
    string tag;
    exp_t  prev;
    vec_t  tbl [12];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        chk("mbc_type", cart_mbc_type, e.typ);
        chk("rom_size", cart_rom_size, e.rom);
        chk("ram_size", cart_ram_size, e.ram);
        chk("cgb_flag", cart_cgb_flag, e.cgb);
        chk("mbc1", mbc1, e.m1);
        chk("mbc1m", mbc1m, e.m1m);
        chk("mbc2", mbc2, e.m2);
        chk("mbc3", mbc3, e.m3);
        chk("mbc5", mbc5, e.m5);
        chk("has_ram", has_ram, e.has_ram);
        chk("ram_mask", ram_mask, e.ram_mask);
        chk("rom_mask", rom_mask, e.rom_mask);
        chk("hdr_valid", hdr_valid, e.valid);
        chk("hdr_chk_ok", hdr_chk_ok, e.chk_ok);
        chk("unsupported", unsupported, e.unsup);
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.typ = 0; e.rom = 0; e.ram = 0; e.cgb = 0;
        e.m1 = 0; e.m1m = 0; e.m2 = 0; e.m3 = 0; e.m5 = 0; e.has_ram = 0;
        e.ram_mask = 0; e.rom_mask = 0; e.valid = 0; e.chk_ok = 0; e.unsup = 0;
        return e;
    endfunction

    function automatic logic [7:0] hb(input int a);
        return sent[a] ? img[a] : 8'h00;
    endfunction

    // Reference: what a header reader would conclude from the bytes actually delivered.
    function automatic exp_t model();
        exp_t       e;
        logic [7:0] c;
        bit         logo_eq;
        e = zero_exp();
        e.valid = 1;
        for (int a = 'h134; a <= 'h14D; a++) if (!sent[a]) e.valid = 0;
        e.typ = hb('h147); e.rom = hb('h148); e.ram = hb('h149); e.cgb = hb('h143);
        c = 0;
        for (int a = 'h134; a <= 'h14C; a++) c = c - hb(a) - 8'd1;
        e.chk_ok = e.valid && (c == hb('h14D));
        e.unsup = !(e.typ inside {[8'h01:8'h03], [8'h05:8'h06], [8'h0F:8'h13], [8'h19:8'h1E],
                                   8'h00, 8'h08, 8'h09});
        if (e.valid) begin
            e.m1 = e.typ inside {[8'h01:8'h03]};
            e.m2 = e.typ inside {[8'h05:8'h06]};
            e.m3 = e.typ inside {[8'h0F:8'h13]};
            e.m5 = e.typ inside {[8'h19:8'h1E]};
            e.has_ram = e.m2 || (e.ram != 0);
            e.rom_mask = (e.rom > 8) ? 9'h1FF : 9'((2 << e.rom) - 1);
            case (e.ram)
                0, 1, 2: e.ram_mask = 0;
                3:       e.ram_mask = 3;
                4:       e.ram_mask = 15;
                5:       e.ram_mask = 7;
                default: e.ram_mask = 15;
            endcase
        end
        logo_eq = 1;
        for (int i = 0; i < 16; i++)
            if (!sent['h104 + i] || !logo2_sent[i] || img['h104 + i] != logo2[i]) logo_eq = 0;
`ifdef GB_MBC1M_DETECT_EN
        e.m1m = e.m1 && (e.rom == 5) && logo_eq;
`else
        e.m1m = 0 && logo_eq;
`endif
        return e;
    endfunction

    task automatic fill_image(input logic [7:0] typ, input logic [7:0] rom, input logic [7:0] ram,
                              input bit corrupt);
        logic [7:0] c;
        for (int a = 'h100; a < 'h160; a++) img[a] = 8'($urandom);
        img['h147] = typ; img['h148] = rom; img['h149] = ram;
        c = 0;
        for (int a = 'h134; a <= 'h14C; a++) c = c - img[a] - 8'd1;
        img['h14D] = c + 8'(corrupt);
        for (int i = 0; i < 16; i++) logo2[i] = img['h104 + i];
    endtask

    function automatic logic [7:0] byte_at(input int a);
        return (a >= 'h40000) ? logo2[a - 'h40104] : img[a];
    endfunction

    task automatic wr_word(input int a, input logic [15:0] d);
        dl_wr   = 1;
        dl_addr = 25'(a) | 25'($urandom_range(1, 0));
        dl_data = d;
        tick();
        dl_wr = 0;
        if ($urandom_range(3, 0) == 0) tick();
    endtask

    task automatic download(input int stop_addr, input int drop_addr, input bit shuffle,
                            input int n_garbage, input bit with_logo2);
        int   addrs[$];
        int   j, t;
        exp_t e;
        foreach (sent[i]) sent[i] = 0;
        foreach (logo2_sent[i]) logo2_sent[i] = 0;
        for (int a = 'h100; a < stop_addr; a += 2) if (a != drop_addr) addrs.push_back(a);
        if (with_logo2) for (int a = 'h40104; a < 'h40114; a += 2) addrs.push_back(a);
        if (shuffle)
            for (int i = addrs.size() - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = addrs[i]; addrs[i] = addrs[j]; addrs[j] = t;
            end
        dl_active = 1;
        tick();
        for (int g = 0; g < n_garbage; g++)
            wr_word(addrs[$urandom_range(addrs.size() - 1, 0)], 16'($urandom));
        foreach (addrs[k]) begin
            wr_word(addrs[k], {byte_at(addrs[k] + 1), byte_at(addrs[k])});
            if (addrs[k] >= 'h40000) begin
                logo2_sent[addrs[k] - 'h40104] = 1; logo2_sent[addrs[k] - 'h40103] = 1;
            end else begin
                sent[addrs[k]] = 1; sent[addrs[k] + 1] = 1;
            end
        end
        check_all(prev);
        // write coincident with the fall must be dropped
        dl_active = 0; dl_wr = 1; dl_addr = 25'h146; dl_data = 16'($urandom);
        tick();
        dl_wr = 0;
        check_all(prev);
        tick();
        e = model();
        check_all(e);
        prev = e;
        tick();
    endtask

    initial begin
        exp_t       e;
        logic [7:0] typ;
        int         drop;
        reset_n = 0; dl_active = 0; dl_wr = 0; dl_addr = 0; dl_data = 0;
        prev = zero_exp();
        repeat (3) tick();
        reset_n = 1;
        tick();
        tag = "reset";
        check_all(zero_exp());

        tbl[0]  = '{8'h00, 8'h00, 8'h00, 0, 0, 9'h001, 4'h0, 0, 1, 0};
        tbl[1]  = '{8'h1B, 8'h06, 8'h03, 1, 5, 9'h07F, 4'h3, 1, 0, 0};
        tbl[2]  = '{8'h06, 8'h00, 8'h00, 0, 2, 9'h001, 4'h0, 1, 1, 0};
        tbl[3]  = '{8'hFC, 8'h00, 8'h00, 0, 0, 9'h001, 4'h0, 0, 1, 1};
        tbl[4]  = '{8'h03, 8'h05, 8'h02, 0, 1, 9'h03F, 4'h0, 1, 1, 0};
        tbl[5]  = '{8'h11, 8'h09, 8'h04, 0, 3, 9'h1FF, 4'hF, 1, 1, 0};
        tbl[6]  = '{8'h09, 8'h08, 8'h05, 0, 0, 9'h1FF, 4'h7, 1, 1, 0};
        tbl[7]  = '{8'h19, 8'h02, 8'h07, 1, 5, 9'h007, 4'hF, 1, 0, 0};
        tbl[8]  = '{8'h0F, 8'h07, 8'h01, 0, 3, 9'h0FF, 4'h0, 1, 1, 0};
        tbl[9]  = '{8'h04, 8'h01, 8'h00, 0, 0, 9'h003, 4'h0, 0, 1, 1};
        tbl[10] = '{8'h13, 8'h03, 8'h03, 0, 3, 9'h00F, 4'h3, 1, 1, 0};
        tbl[11] = '{8'h1E, 8'h04, 8'h06, 0, 5, 9'h01F, 4'hF, 1, 1, 0};

        for (int i = 0; i < 12; i++) begin
            tag = $sformatf("tbl%0d", i);
            fill_image(tbl[i].typ, tbl[i].rom, tbl[i].ram, tbl[i].corrupt);
            download('h160, -1, 0, 0, 0);
            e = zero_exp();
            e.typ = tbl[i].typ; e.rom = tbl[i].rom; e.ram = tbl[i].ram; e.cgb = img['h143];
            e.m1 = (tbl[i].map == 1); e.m2 = (tbl[i].map == 2);
            e.m3 = (tbl[i].map == 3); e.m5 = (tbl[i].map == 5);
            e.has_ram = tbl[i].has_ram; e.ram_mask = tbl[i].ram_mask; e.rom_mask = tbl[i].rom_mask;
            e.valid = 1; e.chk_ok = tbl[i].chk_ok; e.unsup = tbl[i].unsup;
            tag = $sformatf("tbl%0d_exp", i);
            check_all(e);
        end

        tag = "abort";
        fill_image(8'h01, 8'h02, 8'h03, 0);
        download('h140, -1, 0, 0, 0);
        chk("abort_valid", hdr_valid, 0);
        chk("abort_rom_mask", rom_mask, 0);

        tag = "rst_mid";
        fill_image(8'h1B, 8'h05, 8'h03, 0);
        dl_active = 1;
        tick();
        for (int a = 'h100; a < 'h140; a += 2) wr_word(a, {img[a + 1], img[a]});
        reset_n = 0;
        tick();
        reset_n = 1;
        check_all(zero_exp());
        for (int a = 'h140; a < 'h160; a += 2) wr_word(a, {img[a + 1], img[a]});
        dl_active = 0;
        repeat (3) tick();
        check_all(zero_exp());
        prev = zero_exp();

        tag = "logo_dup";
        fill_image(8'h01, 8'h05, 8'h03, 0);
        download('h160, -1, 1, 2, 1);
        chk("mbc1", mbc1, 1);
        chk("mbc1m_dup", mbc1m, EXP_M1M_DUP);
        tag = "logo_diff";
        logo2[12] = logo2[12] ^ 8'h5A;
        download('h160, -1, 1, 0, 1);
        chk("mbc1", mbc1, 1);
        chk("mbc1m_diff", mbc1m, 0);

        for (int r = 0; r < 24; r++) begin
            tag = $sformatf("rnd%0d", r);
            typ = ($urandom_range(3, 0) == 0) ? 8'($urandom) : typ_pool[$urandom_range(11, 0)];
            if ($urandom_range(3, 0) == 0)
                fill_image(8'h02, 8'h05, 8'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
            else
                fill_image(typ, 8'($urandom_range(12, 0)), 8'($urandom_range(7, 0)),
                           1'($urandom_range(1, 0)));
            if ($urandom_range(1, 0) == 1) logo2[$urandom_range(15, 0)] ^= 8'h01;
            drop = ($urandom_range(4, 0) == 0) ? 'h134 + 2 * $urandom_range(12, 0) : -1;
            download('h160, drop, 1, $urandom_range(4, 0), 1'($urandom_range(1, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
